rx_sample_ctrl: RTL

//  Sequencing controller for the UART receive datapath. Detects and qualifies the start bit,

---
 rtl/rx_sample_ctrl_if.sv | 15 +
 rtl/rx_sample_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rx_sample_ctrl_if.sv
// Received-frame handoff from rx_sample_ctrl (master) to its consumer (slave).
// Handshake: the master holds rx_data/parity_err/frame_err stable while rx_valid=1; a frame
// transfers on a rising edge with rx_valid & rx_ready, and rx_valid never drops otherwise.
interface rx_sample_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_err;
  logic                  frame_err;

  modport master (output rx_data, rx_valid, parity_err, frame_err, input rx_ready);
  modport slave  (input rx_data, rx_valid, parity_err, frame_err, output rx_ready);
endinterface

// File: rtl/rx_sample_ctrl.sv
// UART receive sequencer: qualifies the start bit, times mid-bit sampling from the
// oversampling tick, strobes the SIPO/parity/stop checkers and captures finished frames.
module rx_sample_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  input  logic                  baud_tick,
  input  logic                  rx_in,
  input  logic [DATA_WIDTH-1:0] parallel_in,
  input  logic                  parity_bit_error,
  input  logic                  stop_bit_error,
  output logic                  shift,
  output logic                  parity_load,
  output logic                  check_stop,
  output logic                  busy,
  output logic                  overrun,
  output logic [2:0]            state_dbg,
  rx_sample_ctrl_if.master      rx_if
);

  localparam int            CW       = $clog2(OVERSAMPLE);
  localparam int            BW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic          PAR_ON   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [BW-1:0]         r_bitcnt, w_bitcnt_nxt;
  logic                  r_shift, r_parity_load, r_check_stop;
  logic                  w_shift_nxt, w_parity_load_nxt, w_check_stop_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid, r_perr, r_ferr, r_overrun;
  logic                  w_capture, w_drop, w_accept;

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_bitcnt      <= '0;
      r_shift       <= 1'b0;
      r_parity_load <= 1'b0;
      r_check_stop  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_bitcnt      <= w_bitcnt_nxt;
      r_shift       <= w_shift_nxt;
      r_parity_load <= w_parity_load_nxt;
      r_check_stop  <= w_check_stop_nxt;
    end
  end

  // Every state except DONE advances only on baud_tick; strobes are registered one cycle later.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_bitcnt_nxt      = r_bitcnt;
    w_shift_nxt       = 1'b0;
    w_parity_load_nxt = 1'b0;
    w_check_stop_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (baud_tick && !rx_in) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (r_cnt == CNT_MID) begin
            w_cnt_nxt    = '0;
            w_bitcnt_nxt = '0;
            w_state_nxt  = rx_in ? IDLE : DATA;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (r_cnt == CNT_END) begin
            w_shift_nxt  = 1'b1;
            w_cnt_nxt    = '0;
            w_bitcnt_nxt = r_bitcnt + 1'b1;
            if (r_bitcnt == BIT_LAST) w_state_nxt = PAR_ON ? PARITY : STOP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          if (r_cnt == CNT_END) begin
            w_parity_load_nxt = 1'b1;
            w_cnt_nxt         = '0;
            w_state_nxt       = STOP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (r_cnt == CNT_END) begin
            w_check_stop_nxt = 1'b1;
            w_cnt_nxt        = '0;
            w_state_nxt      = DONE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A frame finishing while the previous one is still unaccepted is dropped, not overwritten.
  assign w_capture = (r_state == DONE) && (!r_valid || rx_if.rx_ready);
  assign w_drop    = (r_state == DONE) && r_valid && !rx_if.rx_ready;
  assign w_accept  = r_valid && rx_if.rx_ready;

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      if (w_capture) begin
        r_data  <= parallel_in;
        r_perr  <= parity_bit_error & PAR_ON;
        r_ferr  <= stop_bit_error;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign shift            = r_shift;
  assign parity_load      = r_parity_load;
  assign check_stop       = r_check_stop;
  assign busy             = (r_state != IDLE);
  assign overrun          = r_overrun;
  assign state_dbg        = r_state;
  assign rx_if.rx_data    = r_data;
  assign rx_if.rx_valid   = r_valid;
  assign rx_if.parity_err = r_perr;
  assign rx_if.frame_err  = r_ferr;

endmodule
